// File: rtl/cond_flags_unit_pkg.sv
// Shared constants and helpers for the condition/flags unit and the branch unit.
package cond_flags_unit_pkg;

  // ALU operation codes that produce meaningful carry/overflow.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  // Instruction condition-field encodings.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the packed {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for ALU ops whose carry and overflow outputs are architecturally valid.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cond_flags_unit_cond_check.sv
// Purely combinational condition evaluator: (cond, NZCV) -> pass/fail.
// Kept standalone so the branch unit can reuse the same decode.
module cond_check
  import cond_flags_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode the condition field against the supplied flags.
  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z_s;
      COND_NE: cond_ex = ~z_s;
      COND_CS: cond_ex = c_s;
      COND_CC: cond_ex = ~c_s;
      COND_MI: cond_ex = n_s;
      COND_PL: cond_ex = ~n_s;
      COND_VS: cond_ex = v_s;
      COND_VC: cond_ex = ~v_s;
      COND_HI: cond_ex = c_s & ~z_s;
      COND_LS: cond_ex = ~c_s | z_s;
      COND_GE: cond_ex = (n_s == v_s);
      COND_LT: cond_ex = (n_s != v_s);
      COND_GT: cond_ex = ~z_s & (n_s == v_s);
      COND_LE: cond_ex = z_s | (n_s != v_s);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flags_unit.sv
// Condition evaluation, write-enable gating, NZCV register and overflow
// monitoring (sticky bit plus saturating event counter).
module cond_flags_unit
  import cond_flags_unit_pkg::*;
#(
  parameter int bits  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [bits-1:0]   result,
  input  logic              carry,
  input  logic              ovf,
  input  logic [3:0]        s,
  input  logic [3:0]        cond,
  input  logic              flag_write,
  input  logic              reg_write_in,
  input  logic              mem_write_in,
  input  logic              pc_src_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              ov_clear,
  output logic [3:0]        flags,
  output logic              cond_ex,
  output logic              reg_write,
  output logic              mem_write,
  output logic              pc_src,
  output logic              ov_sticky,
  output logic [CNT_W-1:0]  ov_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [3:0]       flags_q;
  logic [3:0]       flags_d;
  logic             ov_sticky_q;
  logic             ov_sticky_d;
  logic [CNT_W-1:0] ov_count_q;
  logic [CNT_W-1:0] ov_count_d;

  logic             cond_ex_s;
  logic             arith_s;
  logic             upd_s;
  logic             ev_s;
  logic             zero_s;

  // Condition is checked against the architectural (registered) flags,
  // so an instruction never observes its own flag results.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex_s)
  );

  assign arith_s = is_arith(s);
  assign zero_s  = (result == {bits{1'b0}});
  assign upd_s   = flag_write & cond_ex_s & ~stall & ~flush & ~rst;
  assign ev_s    = ovf & arith_s & cond_ex_s & ~stall & ~flush;

  // Next NZCV: N/Z always follow the result, C/V only for add/sub.
  always_comb begin
    flags_d = flags_q;
    if (upd_s) begin
      flags_d[FLAG_N] = result[bits-1];
      flags_d[FLAG_Z] = zero_s;
      if (arith_s) begin
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_V] = ovf;
      end else begin
        flags_d[FLAG_C] = flags_q[FLAG_C];
        flags_d[FLAG_V] = flags_q[FLAG_V];
      end
    end else begin
      flags_d = flags_q;
    end
  end

  // Overflow monitor: clear beats a same-cycle event; counter saturates.
  always_comb begin
    ov_sticky_d = ov_sticky_q;
    ov_count_d  = ov_count_q;
    if (ov_clear) begin
      ov_sticky_d = 1'b0;
      ov_count_d  = CNT_ZERO;
    end else if (ev_s) begin
      ov_sticky_d = 1'b1;
      if (ov_count_q == CNT_MAX) begin
        ov_count_d = ov_count_q;
      end else begin
        ov_count_d = ov_count_q + CNT_ONE;
      end
    end else begin
      ov_sticky_d = ov_sticky_q;
      ov_count_d  = ov_count_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= 4'b0000;
      ov_sticky_q <= 1'b0;
      ov_count_q  <= CNT_ZERO;
    end else begin
      flags_q     <= flags_d;
      ov_sticky_q <= ov_sticky_d;
      ov_count_q  <= ov_count_d;
    end
  end

  assign flags     = flags_q;
  assign cond_ex   = cond_ex_s;
  assign reg_write = reg_write_in & cond_ex_s & ~flush;
  assign mem_write = mem_write_in & cond_ex_s & ~flush;
  assign pc_src    = pc_src_in & cond_ex_s & ~flush;
  assign ov_sticky = ov_sticky_q;
  assign ov_count  = ov_count_q;

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit. Expected values are queued when
// stimulus is applied and popped when the corresponding output is sampled.
module tb_cond_flags_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  logic        carry, ovf;
  logic [3:0]  s, cond;
  logic        flag_write, reg_write_in, mem_write_in, pc_src_in;
  logic        stall, flush, ov_clear;

  logic [3:0]  flags, flags2;
  logic        cond_ex, reg_write, mem_write, pc_src, ov_sticky;
  logic        cond_ex2, reg_write2, mem_write2, pc_src2, ov_sticky2;
  logic [15:0] ov_count;
  logic [1:0]  ov_count2;

  logic [31:0] sb_q[$];
  logic [31:0] exp_v;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  cond_flags_unit #(.bits(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .result(result), .carry(carry), .ovf(ovf), .s(s),
    .cond(cond), .flag_write(flag_write), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .stall(stall),
    .flush(flush), .ov_clear(ov_clear), .flags(flags), .cond_ex(cond_ex),
    .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .ov_sticky(ov_sticky), .ov_count(ov_count)
  );

  // Narrow-counter instance for the saturation check; shares all inputs.
  cond_flags_unit #(.bits(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .result(result), .carry(carry), .ovf(ovf), .s(s),
    .cond(cond), .flag_write(flag_write), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .pc_src_in(pc_src_in), .stall(stall),
    .flush(flush), .ov_clear(ov_clear), .flags(flags2), .cond_ex(cond_ex2),
    .reg_write(reg_write2), .mem_write(mem_write2), .pc_src(pc_src2),
    .ov_sticky(ov_sticky2), .ov_count(ov_count2)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 1'b0; result = 32'h0000_0001; carry = 1'b0; ovf = 1'b0;
    s = 4'b0010; cond = 4'b1110; flag_write = 1'b0;
    reg_write_in = 1'b0; mem_write_in = 1'b0; pc_src_in = 1'b0;
    stall = 1'b0; flush = 1'b0; ov_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; flag_write = 1'b1; s = 4'b0000; ovf = 1'b1; result = 32'h8000_0000;
    tick(); tick();
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    idle();
    cond = 4'b0001; sb_q.push_back(32'h1);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL reset_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL reset_count: got %0d want %0d", ov_count, exp_v[15:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_sticky !== exp_v[0]) begin n_mis++; $display("FAIL reset_sticky: got %b want %b", ov_sticky, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (cond_ex !== exp_v[0]) begin n_mis++; $display("FAIL reset_ne: got %b want %b", cond_ex, exp_v[0]); end
    cond = 4'b0000; reg_write_in = 1'b1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (cond_ex !== exp_v[0]) begin n_mis++; $display("FAIL reset_eq: got %b want %b", cond_ex, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (reg_write !== exp_v[0]) begin n_mis++; $display("FAIL reset_eq_regwr: got %b want %b", reg_write, exp_v[0]); end
  endtask

  // Sweep all 16 condition codes against the current flags; table bit i is cond i.
  task automatic sweep_conds(input logic [15:0] table_v, input string tag);
    reg_write_in = 1'b1; mem_write_in = 1'b1; pc_src_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      sb_q.push_back({31'h0, table_v[i]});
      #1;
      exp_v = sb_q.pop_front(); n_cmp++;
      if (cond_ex !== exp_v[0] || reg_write !== exp_v[0] || mem_write !== exp_v[0] || pc_src !== exp_v[0]) begin
        n_mis++;
        $display("FAIL %s_cond%0d: got ex=%b rw=%b mw=%b pc=%b want %b", tag, i, cond_ex, reg_write, mem_write, pc_src, exp_v[0]);
      end
    end
    reg_write_in = 1'b0; mem_write_in = 1'b0; pc_src_in = 1'b0;
  endtask

  task automatic test_arith_flags();
    idle();
    s = 4'b0001; result = 32'h0; carry = 1'b1; ovf = 1'b0; flag_write = 1'b1; cond = 4'b1110;
    sb_q.push_back(32'h6);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL sub_flags: got %b want %b", flags, exp_v[3:0]); end
    // flags 0110: N=0 Z=1 C=1 V=0
    sweep_conds(16'hE6A5, "z1c1");
  endtask

  task automatic test_logic_op();
    idle();
    s = 4'b0010; result = 32'h8000_0000; carry = 1'b0; ovf = 1'b1; flag_write = 1'b1;
    sb_q.push_back(32'hA); sb_q.push_back(32'h0);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL logic_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL logic_no_event: got %0d want %0d", ov_count, exp_v[15:0]); end
    // flags 1010: N=1 Z=0 C=1 V=0
    sweep_conds(16'hE996, "n1c1");
    // Failing condition blocks both flag update and overflow event.
    cond = 4'b0000; flag_write = 1'b1; s = 4'b0000; result = 32'h0; ovf = 1'b1;
    sb_q.push_back(32'hA); sb_q.push_back(32'h0);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL condfail_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL condfail_count: got %0d want %0d", ov_count, exp_v[15:0]); end
  endtask

  task automatic test_overflow();
    idle();
    s = 4'b0000; ovf = 1'b1; cond = 4'b1110; flag_write = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back(32'(k));
      tick();
      exp_v = sb_q.pop_front(); n_cmp++;
      if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL ov_count_step%0d: got %0d want %0d", k, ov_count, exp_v[15:0]); end
    end
    sb_q.push_back(32'h1); sb_q.push_back(32'hA);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_sticky !== exp_v[0]) begin n_mis++; $display("FAIL ov_sticky_set: got %b want %b", ov_sticky, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL ov_flags_hold: got %b want %b", flags, exp_v[3:0]); end
    ov_clear = 1'b1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL clear_count: got %0d want %0d", ov_count, exp_v[15:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_sticky !== exp_v[0]) begin n_mis++; $display("FAIL clear_sticky: got %b want %b", ov_sticky, exp_v[0]); end
  endtask

  task automatic test_saturate();
    idle();
    s = 4'b0001; ovf = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    idle();
    sb_q.push_back(32'h3); sb_q.push_back(32'h1); sb_q.push_back(32'h5);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count2 !== exp_v[1:0]) begin n_mis++; $display("FAIL sat_count: got %0d want %0d", ov_count2, exp_v[1:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_sticky2 !== exp_v[0]) begin n_mis++; $display("FAIL sat_sticky: got %b want %b", ov_sticky2, exp_v[0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL wide_count: got %0d want %0d", ov_count, exp_v[15:0]); end
  endtask

  task automatic test_stall_flush();
    idle();
    stall = 1'b1; flag_write = 1'b1; ovf = 1'b1; s = 4'b0000; result = 32'h0; carry = 1'b0;
    reg_write_in = 1'b1; mem_write_in = 1'b1; pc_src_in = 1'b1;
    sb_q.push_back(32'h7);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if ({reg_write, mem_write, pc_src} !== exp_v[2:0]) begin n_mis++; $display("FAIL stall_gating: got %b want %b", {reg_write, mem_write, pc_src}, exp_v[2:0]); end
    sb_q.push_back(32'hA); sb_q.push_back(32'h5);
    tick();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL stall_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL stall_count: got %0d want %0d", ov_count, exp_v[15:0]); end
    ov_clear = 1'b1;
    sb_q.push_back(32'h0);
    tick();
    ov_clear = 1'b0;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL stall_clear: got %0d want %0d", ov_count, exp_v[15:0]); end
    stall = 1'b0; flush = 1'b1;
    sb_q.push_back(32'h0);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if ({reg_write, mem_write, pc_src} !== exp_v[2:0]) begin n_mis++; $display("FAIL flush_gating: got %b want %b", {reg_write, mem_write, pc_src}, exp_v[2:0]); end
    sb_q.push_back(32'hA); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL flush_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL flush_count: got %0d want %0d", ov_count, exp_v[15:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_sticky !== exp_v[0]) begin n_mis++; $display("FAIL flush_sticky: got %b want %b", ov_sticky, exp_v[0]); end
  endtask

  task automatic test_back_to_back();
    idle();
    // Flags are 1010 (Z=0): NE passes on old flags while this op sets Z.
    cond = 4'b0001; flag_write = 1'b1; s = 4'b0001; result = 32'h0; carry = 1'b1; ovf = 1'b0;
    sb_q.push_back(32'h1);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (cond_ex !== exp_v[0]) begin n_mis++; $display("FAIL b2b_old_flags: got %b want %b", cond_ex, exp_v[0]); end
    tick();
    idle();
    cond = 4'b0001; reg_write_in = 1'b1;
    sb_q.push_back(32'h6); sb_q.push_back(32'h0);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL b2b_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (reg_write !== exp_v[0]) begin n_mis++; $display("FAIL b2b_ne_regwr: got %b want %b", reg_write, exp_v[0]); end
    cond = 4'b0000;
    sb_q.push_back(32'h1);
    #1;
    exp_v = sb_q.pop_front(); n_cmp++;
    if (reg_write !== exp_v[0]) begin n_mis++; $display("FAIL b2b_eq_regwr: got %b want %b", reg_write, exp_v[0]); end
    // Reset wins over a simultaneous flag update and overflow event.
    idle();
    rst = 1'b1; flag_write = 1'b1; s = 4'b0000; ovf = 1'b1; result = 32'h8000_0000; carry = 1'b1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick();
    idle();
    exp_v = sb_q.pop_front(); n_cmp++;
    if (flags !== exp_v[3:0]) begin n_mis++; $display("FAIL rst_wins_flags: got %b want %b", flags, exp_v[3:0]); end
    exp_v = sb_q.pop_front(); n_cmp++;
    if (ov_count !== exp_v[15:0]) begin n_mis++; $display("FAIL rst_wins_count: got %0d want %0d", ov_count, exp_v[15:0]); end
  endtask

  initial begin
    idle();
    test_reset();
    test_arith_flags();
    test_logic_op();
    test_overflow();
    test_saturate();
    test_stall_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cond_flags_unit.md
Name: cond_flags_unit

Overview:
- Downstream consumer of the ALU flag logic.
- Takes the ALU result plus the carry and overflow flags from the current instruction, and evaluates the instruction's 4-bit condition field against the architectural NZCV register.
- Gates the register, memory and PC write enables, and latches new NZCV when the instruction sets flags.
- Also keeps a sticky overflow bit and a saturating overflow-event counter, so the reverb datapath can report arithmetic clipping to software.

Parameters:
- bits, 32: ALU result width.
- CNT_W, 16: width of the overflow-event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- result  input  bits  ALU result of current instruction.
- carry  input  1  ALU carry-out.
- ovf  input  1  ALU overflow flag; only meaningful for add/sub.
- s  input  4  ALU control; 4'b0000 add, 4'b0001 sub, others non-arithmetic.
- cond  input  4  instruction condition field.
- flag_write  input  1  instruction requests NZCV update.
- reg_write_in  input  1  decoder register-write request.
- mem_write_in  input  1  decoder memory-write request.
- pc_src_in  input  1  decoder PC-write/branch request.
- stall  input  1  hold all state this cycle.
- flush  input  1  squash current instruction.
- ov_clear  input  1  clear sticky bit and counter.
- flags  output  4  registered {N,Z,C,V}.
- cond_ex  output  1  condition passed (combinational).
- reg_write  output  1  reg_write_in & cond_ex & !flush.
- mem_write  output  1  mem_write_in & cond_ex & !flush.
- pc_src  output  1  pc_src_in & cond_ex & !flush.
- ov_sticky  output  1  overflow seen since last clear.
- ov_count  output  CNT_W  number of overflow events, saturating.

Behaviour:
- Reset (rst=1 at edge): flags=4'b0000, ov_sticky=0, ov_count=0. Reset wins over every other input.
- cond_ex is evaluated combinationally against registered flags, never against this instruction's own new flags. Encoding:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 treated as 1
- Output gating: when flush=1, all three gated outputs are 0 regardless of cond_ex. stall does not gate outputs; the pipeline already holds them.
- Flag update enable: upd = flag_write & cond_ex & !stall & !flush & !rst.
- On upd:
  - N <= result[bits-1]; Z <= (result == 0).
  - Arithmetic ops (s=0000 or 0001) also load C <= carry and V <= ovf.
  - Non-arithmetic ops leave C and V unchanged.
- Overflow event: ev = ovf & arithmetic(s) & cond_ex & !stall & !flush. An event counts even when flag_write=0.
- Counter:
  - ov_clear=1 (no rst): ov_sticky <= 0 and ov_count <= 0. ev in the same cycle is discarded; clear has priority.
  - Otherwise, on ev: ov_sticky <= 1, and ov_count increments by 1 unless it is already all ones, in which case it holds (no wrap).
- stall=1: flags, ov_sticky and ov_count hold. ov_clear is still honoured during stall.
- Latency: new flags are visible on the flags output one cycle after the updating instruction. Back-to-back flag-setting then conditional instruction sees the updated value on the next cycle.

Decomposition:
- Shared package:
  - ALU op constants ALU_ADD=4'b0000 and ALU_SUB=4'b0001.
  - Condition-code constants COND_EQ..COND_AL.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: cond_check, purely combinational, mapping (cond, flags) to cond_ex. It is instantiated once here and reusable by the branch unit.
- Flag register and overflow counter stay in the top module.

Test Plan:
- Reset, then cond=0001 (NE): flags=0000 and cond_ex=1. Then cond=0000 (EQ): cond_ex=0, reg_write=0 with reg_write_in=1.
- s=0001, result=0, carry=1, ovf=0, flag_write=1, cond=1110: next cycle flags=4'b0110. Then cond=1000 (HI): cond_ex=0. Then cond=0010 (CS): cond_ex=1.
- With flags=0110, apply s=0010 (logic op), result=32'h8000_0000, flag_write=1: flags become 4'b1010, with C and V retained.
- Three cycles of s=0000, ovf=1, cond=1110, flag_write=0: ov_sticky=1 and ov_count=3, flags unchanged. Then ov_clear=1 together with another ov event: ov_count=0 and ov_sticky=0.
- CNT_W=2: five overflow events give ov_count=3 (saturated, no wrap to 0).
- flag_write=1, ovf=1 with stall=1: flags and counter hold. Repeat with flush=1: no updates, and reg_write, mem_write and pc_src are all 0.
